// File: rtl/armleocpu_axi_bram_pkg.sv
// Shared AXI response/size encodings and request classification for the BRAM responder.
`ifndef ARMLEOCPU_DEFINES
`define ARMLEOCPU_DEFINES
`define ARMLEOCPU_AXI_RESP_OKAY   2'b00
`define ARMLEOCPU_AXI_RESP_EXOKAY 2'b01
`define ARMLEOCPU_AXI_RESP_SLVERR 2'b10
`define ARMLEOCPU_AXI_RESP_DECERR 2'b11
`define ARMLEOCPU_AXI_SIZE_WORD   3'b010
`endif

package armleocpu_axi_bram_pkg;

   typedef logic [1:0] axi_resp_t;

   localparam axi_resp_t  RESP_OKAY   = `ARMLEOCPU_AXI_RESP_OKAY;
   localparam axi_resp_t  RESP_EXOKAY = `ARMLEOCPU_AXI_RESP_EXOKAY;
   localparam axi_resp_t  RESP_SLVERR = `ARMLEOCPU_AXI_RESP_SLVERR;
   localparam axi_resp_t  RESP_DECERR = `ARMLEOCPU_AXI_RESP_DECERR;
   localparam logic [2:0] SIZE_WORD   = `ARMLEOCPU_AXI_SIZE_WORD;

   // off is the byte offset from BASE_ADDR; base is span-aligned so off[1:0] mirrors addr[1:0]
   function automatic axi_resp_t classify(input logic [31:0] off, input logic [31:0] span,
                                          input logic [2:0] size, input logic [7:0] len);
      if (off >= span)
         return RESP_DECERR;
      else if (off[1:0] != 2'b00 || size != SIZE_WORD || len != 8'd0)
         return RESP_SLVERR;
      else
         return RESP_OKAY;
   endfunction

endpackage

// File: rtl/armleocpu_axi_bram_if.sv
// AXI4 bus bundle between the execute-stage data master and the BRAM responder.
interface armleocpu_axi_bram_if;
   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awlock;
   logic [2:0]  awprot;
   logic        wvalid, wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic        buser;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arlock;
   logic [2:0]  arprot;
   logic        rvalid, rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        ruser;

   modport slave (
      input  awvalid, awaddr, awlen, awsize, awburst, awlock, awprot,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp, buser,
      input  bready,
      input  arvalid, araddr, arlen, arsize, arburst, arlock, arprot,
      output arready,
      output rvalid, rdata, rresp, rlast, ruser,
      input  rready
   );

   modport master (
      output awvalid, awaddr, awlen, awsize, awburst, awlock, awprot,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp, buser,
      output bready,
      output arvalid, araddr, arlen, arsize, arburst, arlock, arprot,
      input  arready,
      input  rvalid, rdata, rresp, rlast, ruser,
      output rready
   );
endinterface

// File: rtl/armleocpu_mem_1rw.sv
// Single-port synchronous word RAM: one-cycle registered read, byte-enable write.
module armleocpu_mem_1rw #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  i_read,
   input  logic                  i_write,
   input  logic [DEPTH_LOG2-1:0] i_addr,
   input  logic [3:0]            i_wstrb,
   input  logic [31:0]           i_wdata,
   output logic [31:0]           o_rdata
);
   logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];

   always_ff @(posedge clk) begin
      if (i_write) begin
         for (int b = 0; b < 4; b++)
            if (i_wstrb[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
      if (i_read) o_rdata <= r_mem[i_addr];
   end
endmodule

// File: rtl/armleocpu_axi_bram.sv
// AXI4 single-beat word responder over on-chip RAM with one LR/SC reservation.
//  state        | meaning
//  S_IDLE       | arbitrate AR vs AW, capture request classification
//  S_READ_RESP  | RVALID held, returning LEN+1 beats
//  S_WRITE_DATA | WREADY high, consuming LEN+1 W beats
//  S_WRITE_RESP | BVALID held until BREADY
module armleocpu_axi_bram
   import armleocpu_axi_bram_pkg::*;
#(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input logic                 clk,
   input logic                 rst_n,
   armleocpu_axi_bram_if.slave s_axi
);
   typedef enum logic [1:0] {S_IDLE, S_READ_RESP, S_WRITE_DATA, S_WRITE_RESP} state_t;
   localparam logic [31:0] SPAN = 32'd4 << DEPTH_LOG2;

   state_t                r_state, w_next;
   logic                  r_rr_turn;  // 0: read has priority
   logic [7:0]            r_len;
   axi_resp_t             r_resp;
   logic [DEPTH_LOG2-1:0] r_addr;
   logic                  r_wr_ok, r_excl;
   logic                  r_res_valid;
   logic [DEPTH_LOG2-1:0] r_res_addr;

   logic [31:0]           w_ar_off, w_aw_off, w_mem_rdata;
   logic [DEPTH_LOG2-1:0] w_ar_word, w_aw_word, w_mem_addr;
   axi_resp_t             w_ar_cls, w_aw_cls;
   logic w_grant_read, w_grant_write, w_ar_hs, w_aw_hs, w_r_hs, w_w_hs;
   logic w_aw_match, w_wlast_ok, w_mem_we, w_mem_re, w_unused;

   assign w_ar_off      = s_axi.araddr - BASE_ADDR;
   assign w_aw_off      = s_axi.awaddr - BASE_ADDR;
   assign w_ar_word     = w_ar_off[DEPTH_LOG2+1:2];
   assign w_aw_word     = w_aw_off[DEPTH_LOG2+1:2];
   assign w_ar_cls      = classify(w_ar_off, SPAN, s_axi.arsize, s_axi.arlen);
   assign w_aw_cls      = classify(w_aw_off, SPAN, s_axi.awsize, s_axi.awlen);
   assign w_grant_read  = s_axi.arvalid && (!s_axi.awvalid || !r_rr_turn);
   assign w_grant_write = s_axi.awvalid && !w_grant_read;
   assign w_ar_hs       = (r_state == S_IDLE) && w_grant_read;
   assign w_aw_hs       = (r_state == S_IDLE) && w_grant_write;
   assign w_r_hs        = (r_state == S_READ_RESP) && s_axi.rready;
   assign w_w_hs        = (r_state == S_WRITE_DATA) && s_axi.wvalid;
   assign w_aw_match    = r_res_valid && (r_res_addr == w_aw_word);
   assign w_wlast_ok    = (r_len == 8'd0) == s_axi.wlast;
   assign w_mem_we      = w_w_hs && (r_len == 8'd0) && s_axi.wlast && r_wr_ok;
   assign w_mem_re      = w_ar_hs && (w_ar_cls == RESP_OKAY);
   assign w_mem_addr    = (r_state == S_IDLE) ? w_ar_word : r_addr;
   assign w_unused      = ^{s_axi.awburst, s_axi.awprot, s_axi.arburst, s_axi.arprot};

   armleocpu_mem_1rw #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
      .clk     (clk),
      .i_read  (w_mem_re),
      .i_write (w_mem_we),
      .i_addr  (w_mem_addr),
      .i_wstrb (s_axi.wstrb),
      .i_wdata (s_axi.wdata),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (w_ar_hs) w_next = S_READ_RESP;
                       else if (w_aw_hs) w_next = S_WRITE_DATA;
         S_READ_RESP:  if (w_r_hs && r_len == 8'd0) w_next = S_IDLE;
         S_WRITE_DATA: if (w_w_hs && r_len == 8'd0) w_next = S_WRITE_RESP;
         S_WRITE_RESP: if (s_axi.bready) w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   always_comb begin
      s_axi.arready = w_ar_hs;
      s_axi.awready = w_aw_hs;
      s_axi.wready  = (r_state == S_WRITE_DATA);
      s_axi.bvalid  = (r_state == S_WRITE_RESP);
      s_axi.bresp   = (r_state == S_WRITE_RESP) ? r_resp : RESP_OKAY;
      s_axi.buser   = 1'b0;
      s_axi.rvalid  = (r_state == S_READ_RESP);
      s_axi.rresp   = (r_state == S_READ_RESP) ? r_resp : RESP_OKAY;
      s_axi.rlast   = (r_state == S_READ_RESP) && (r_len == 8'd0);
      s_axi.rdata   = (r_state == S_READ_RESP && !r_resp[1]) ? w_mem_rdata : 32'd0;
      s_axi.ruser   = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_turn   <= 1'b0;
         r_len       <= 8'd0;
         r_resp      <= RESP_OKAY;
         r_addr      <= '0;
         r_wr_ok     <= 1'b0;
         r_excl      <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_addr  <= '0;
      end else begin
         if (w_ar_hs) begin
            r_rr_turn <= ~r_rr_turn;
            r_len     <= s_axi.arlen;
            r_addr    <= w_ar_word;
            r_resp    <= (w_ar_cls == RESP_OKAY && s_axi.arlock) ? RESP_EXOKAY : w_ar_cls;
            if (w_ar_cls == RESP_OKAY && s_axi.arlock) begin
               r_res_valid <= 1'b1;
               r_res_addr  <= w_ar_word;
            end
         end else if (w_aw_hs) begin
            r_rr_turn <= ~r_rr_turn;
            r_len     <= s_axi.awlen;
            r_addr    <= w_aw_word;
            r_excl    <= s_axi.awlock;
            r_wr_ok   <= (w_aw_cls == RESP_OKAY) && (!s_axi.awlock || w_aw_match);
            if (w_aw_cls != RESP_OKAY)           r_resp <= w_aw_cls;
            else if (s_axi.awlock && w_aw_match) r_resp <= RESP_EXOKAY;
            else                                 r_resp <= RESP_OKAY;
         end
         if ((w_r_hs || w_w_hs) && r_len != 8'd0) r_len <= r_len - 8'd1;
         if (w_w_hs && !w_wlast_ok && !r_resp[1]) r_resp <= RESP_SLVERR;
         // a committed SC, or any plain store hitting the reserved word, drops the reservation
         if (w_mem_we && (r_excl || r_res_addr == r_addr)) r_res_valid <= 1'b0;
      end
   end
endmodule
